// File: rtl/sevenseg_decoder.sv
// Readback monitor for a multiplexed active-low two-digit score display.
// Optional input synchronizer: define SEVENSEG_DECODER_SYNC_EN.
module sevenseg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int BLANK_TIMEOUT = 200000,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [6:0] score,
    output logic       score_valid,
    output logic       score_changed,
    output logic       display_on,
    output logic       seg_err,
    output logic [7:0] err_count
);

    typedef enum logic {ST_OFF, ST_ON} state_t;

    localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ACC_AT    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_TIMEOUT);

    // {legal, digit}; legal=0 for any pattern that is not a decimal digit
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0010000: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    logic [10:0] samp;

`ifdef SEVENSEG_DECODER_SYNC_EN
    logic [10:0] sync_p0_q, sync_p1_q;

    // Reset to all-ones so the synchronizer presents a blank display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0_q <= '1;
            sync_p1_q <= '1;
        end else begin
            sync_p0_q <= {an, seg};
            sync_p1_q <= sync_p0_q;
        end
    end

    assign samp = sync_p1_q;
`else
    assign samp = {an, seg};
`endif

    logic [10:0]      last_q, last_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] blank_q, blank_d;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic             got_tens_q, got_tens_d, got_ones_q, got_ones_d;
    logic [6:0]       score_q, score_d;
    logic             score_valid_q, score_valid_d;
    logic             score_changed_q, score_changed_d;
    logic             seg_err_q, seg_err_d;
    logic [7:0]       err_count_q, err_count_d;
    state_t           state_q, state_d;

    logic [3:0] samp_an;
    logic [4:0] dec;
    logic       accept, legal_acc, pair_done;
    logic [6:0] score_new;

    always_comb begin
        samp_an         = samp[10:7];
        dec             = decode_seg(samp[6:0]);
        last_d          = samp;
        stab_d          = (samp == last_q) ? sat_inc(stab_q, STAB_MAX) : CNT_W'(1);
        accept          = (samp == last_q) && (stab_q == ACC_AT);
        blank_d         = (samp_an == 4'b1111) ? sat_inc(blank_q, BLANK_MAX) : '0;
        tens_d          = tens_q;
        ones_d          = ones_q;
        got_tens_d      = got_tens_q;
        got_ones_d      = got_ones_q;
        score_d         = score_q;
        score_valid_d   = 1'b0;
        score_changed_d = 1'b0;
        seg_err_d       = 1'b0;
        state_d         = state_q;
        legal_acc       = 1'b0;
        pair_done       = 1'b0;
        score_new       = 7'd0;

        if (accept) begin
            case (samp_an)
                4'b1110: begin
                    if (dec[4]) begin
                        ones_d     = dec[3:0];
                        got_ones_d = 1'b1;
                        legal_acc  = 1'b1;
                        pair_done  = got_tens_q;
                    end else begin
                        seg_err_d = 1'b1;
                    end
                end
                4'b1101: begin
                    if (dec[4]) begin
                        tens_d     = dec[3:0];
                        got_tens_d = 1'b1;
                        legal_acc  = 1'b1;
                        pair_done  = got_ones_q;
                    end else begin
                        seg_err_d = 1'b1;
                    end
                end
                4'b1111: ;
                default: seg_err_d = 1'b1;
            endcase
        end

        // Publish uses the digit accepted on this very edge.
        if (pair_done) begin
            score_new       = 7'(tens_d) * 7'd10 + 7'(ones_d);
            score_d         = score_new;
            score_valid_d   = 1'b1;
            score_changed_d = (score_new != score_q);
            got_tens_d      = 1'b0;
            got_ones_d      = 1'b0;
        end

        case (state_q)
            ST_OFF: if (legal_acc) state_d = ST_ON;
            ST_ON: begin
                if (blank_d == BLANK_MAX) begin
                    state_d    = ST_OFF;
                    got_tens_d = 1'b0;
                    got_ones_d = 1'b0;
                end
            end
            default: state_d = ST_OFF;
        endcase

        err_count_d = (seg_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q          <= '0;
            stab_q          <= '0;
            blank_q         <= '0;
            tens_q          <= '0;
            ones_q          <= '0;
            got_tens_q      <= 1'b0;
            got_ones_q      <= 1'b0;
            score_q         <= '0;
            score_valid_q   <= 1'b0;
            score_changed_q <= 1'b0;
            seg_err_q       <= 1'b0;
            err_count_q     <= '0;
            state_q         <= ST_OFF;
        end else begin
            last_q          <= last_d;
            stab_q          <= stab_d;
            blank_q         <= blank_d;
            tens_q          <= tens_d;
            ones_q          <= ones_d;
            got_tens_q      <= got_tens_d;
            got_ones_q      <= got_ones_d;
            score_q         <= score_d;
            score_valid_q   <= score_valid_d;
            score_changed_q <= score_changed_d;
            seg_err_q       <= seg_err_d;
            err_count_q     <= err_count_d;
            state_q         <= state_d;
        end
    end

    assign score         = score_q;
    assign score_valid   = score_valid_q;
    assign score_changed = score_changed_q;
    assign display_on    = (state_q == ST_ON);
    assign seg_err       = seg_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Directed, table-driven bench for sevenseg_decoder (STABLE_CYCLES=4, BLANK_TIMEOUT=16).
module tb_sevenseg_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg;
    logic [3:0] an;
    logic [6:0] score;
    logic       score_valid, score_changed, display_on, seg_err;
    logic [7:0] err_count;

    sevenseg_decoder #(
        .STABLE_CYCLES(4),
        .BLANK_TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg(seg),
        .an(an),
        .score(score),
        .score_valid(score_valid),
        .score_changed(score_changed),
        .display_on(display_on),
        .seg_err(seg_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         n;
        int         score;
        int         valid;
        int         changed;
        int         disp;
        int         err;
        int         errcnt;
        int         vp;
        int         ep;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int ecnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (score_valid) vcnt++;
        if (seg_err) ecnt++;
    endtask

    task automatic add(input logic [3:0] a, input logic [6:0] s, input int n,
                       input int sc, input int v, input int c, input int d,
                       input int e, input int ec, input int vp, input int ep);
        vec_t r;
        r.an = a; r.seg = s; r.n = n; r.score = sc; r.valid = v; r.changed = c;
        r.disp = d; r.err = e; r.errcnt = ec; r.vp = vp; r.ep = ep;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // seg codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 blank=7F
        add(4'b1111, 7'h7F,  3,  0, 0, 0, 0, 0, 0, 0, 0);
        add(4'b1101, 7'h24,  6,  0, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1110, 7'h12,  4, 25, 1, 1, 1, 0, 0, 1, 0);
        add(4'b1110, 7'h12,  2, 25, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1101, 7'h24,  6, 25, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1110, 7'h12,  4, 25, 1, 0, 1, 0, 0, 1, 0);
        add(4'b1110, 7'h12,  2, 25, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1110, 7'h79,  3, 25, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1101, 7'h30,  6, 25, 0, 0, 1, 0, 0, 0, 0);
        add(4'b1110, 7'h7F,  4, 25, 0, 0, 1, 1, 1, 0, 1);
        add(4'b1110, 7'h7F,  1, 25, 0, 0, 1, 0, 1, 0, 0);
        add(4'b1100, 7'h24,  4, 25, 0, 0, 1, 1, 2, 0, 1);
        add(4'b1110, 7'h19,  6, 34, 0, 0, 1, 0, 2, 1, 0);
        add(4'b1101, 7'h24,  6, 34, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1110, 7'h12,  4, 25, 1, 1, 1, 0, 2, 1, 0);
        add(4'b1101, 7'h78,  6, 25, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1111, 7'h7F, 15, 25, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1111, 7'h7F,  1, 25, 0, 0, 0, 0, 2, 0, 0);
        add(4'b1111, 7'h7F,  4, 25, 0, 0, 0, 0, 2, 0, 0);
        add(4'b1110, 7'h10,  6, 25, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1101, 7'h10,  4, 99, 1, 1, 1, 0, 2, 1, 0);
        add(4'b1101, 7'h79,  6, 99, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1101, 7'h19,  6, 99, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1110, 7'h40,  4, 40, 1, 1, 1, 0, 2, 1, 0);
        add(4'b1101, 7'h02,  6, 40, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1110, 7'h40,  4, 60, 1, 1, 1, 0, 2, 1, 0);
        add(4'b1101, 7'h79,  6, 60, 0, 0, 1, 0, 2, 0, 0);
        add(4'b1110, 7'h79,  4, 11, 1, 1, 1, 0, 2, 1, 0);

        an = 4'b1111;
        seg = 7'h7F;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst score", int'(score), 0);
        check("rst valid", int'(score_valid), 0);
        check("rst changed", int'(score_changed), 0);
        check("rst display_on", int'(display_on), 0);
        check("rst seg_err", int'(seg_err), 0);
        check("rst err_count", int'(err_count), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            an = tbl[i].an;
            seg = tbl[i].seg;
            vcnt = 0;
            ecnt = 0;
            repeat (tbl[i].n) step();
            check($sformatf("v%0d score", i), int'(score), tbl[i].score);
            check($sformatf("v%0d valid", i), int'(score_valid), tbl[i].valid);
            check($sformatf("v%0d changed", i), int'(score_changed), tbl[i].changed);
            check($sformatf("v%0d display_on", i), int'(display_on), tbl[i].disp);
            check($sformatf("v%0d seg_err", i), int'(seg_err), tbl[i].err);
            check($sformatf("v%0d err_count", i), int'(err_count), tbl[i].errcnt);
            check($sformatf("v%0d valid_pulses", i), vcnt, tbl[i].vp);
            check($sformatf("v%0d err_pulses", i), ecnt, tbl[i].ep);
        end

        // err_count saturation: 260 more illegal windows on top of the 2 seen
        an = 4'b1100;
        ecnt = 0;
        for (int w = 0; w < 260; w++) begin
            seg = w[0] ? 7'h7F : 7'h00;
            repeat (4) step();
        end
        check("sat err_pulses", ecnt, 260);
        check("sat err_count", int'(err_count), 255);

        // Reset in the middle of a tens-7 stability window
        an = 4'b1101;
        seg = 7'h78;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("mid rst score", int'(score), 0);
        check("mid rst valid", int'(score_valid), 0);
        check("mid rst changed", int'(score_changed), 0);
        check("mid rst display_on", int'(display_on), 0);
        check("mid rst seg_err", int'(seg_err), 0);
        check("mid rst err_count", int'(err_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (3) step();
        check("post rst 3cyc display_on", int'(display_on), 0);
        an = 4'b1110;
        seg = 7'h00;
        repeat (6) step();
        check("post rst ones8 display_on", int'(display_on), 1);
        check("post rst ones8 score", int'(score), 0);
        check("post rst ones8 pulses", vcnt, 0);
        an = 4'b1101;
        seg = 7'h78;
        repeat (4) step();
        check("post rst 78 score", int'(score), 78);
        check("post rst 78 valid", int'(score_valid), 1);
        check("post rst 78 changed", int'(score_changed), 1);
        check("post rst 78 pulses", vcnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
